// File: rtl/disp_pkg.sv
// Shared types, defaults and the brightness-to-on-time helper for the display scan path.
package disp_pkg;

    localparam int NUM_DIGITS_DEF   = 8;
    localparam int DIGIT_W_DEF      = 4;
    localparam int PRESCALE_DEF     = 1000;
    localparam int BLANK_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } disp_state_e;

    // Anode on-time in cycles: (b+1)/8 of the drive window, rounded down.
    function automatic int unsigned on_cycles(input int unsigned b,
                                              input int unsigned prescale,
                                              input int unsigned blank);
        return ((b + 1) * (prescale - blank)) >> 3;
    endfunction

endpackage

// File: rtl/disp_digit_buf.sv
// Double-buffered digit store: shadow written by the host, active copied from shadow on apply.
module disp_digit_buf
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF,
    localparam int AW        = $clog2(NUM_DIGITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic               apply,
    input  logic [AW-1:0]      rd_addr,
    output logic [DIGIT_W-1:0] rd_data
);

    logic [DIGIT_W-1:0] shadow_q [NUM_DIGITS];
    logic [DIGIT_W-1:0] active_q [NUM_DIGITS];

    // The copy takes the pre-edge shadow, so a same-cycle write waits for the next apply.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (apply) active_q <= shadow_q;
            if (wr_en) shadow_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = active_q[rd_addr];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed display scan controller: slot/digit timing, dead-time blanking, PWM anode
// drive and tear-free frame commits.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int PRESCALE     = PRESCALE_DEF,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
    parameter int DIGIT_W      = DIGIT_W_DEF,
    localparam int AW          = $clog2(NUM_DIGITS),
    localparam int SW          = $clog2(PRESCALE)
) (
    input  logic                  eclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DIGIT_W-1:0]    wr_data,
    input  logic                  commit,
    input  logic [2:0]            brightness,
    output logic [AW-1:0]         digit_idx,
    output logic [DIGIT_W-1:0]    digit_val,
    output logic [NUM_DIGITS-1:0] an_sel,
    output logic                  frame_start,
    output logic                  commit_ack,
    output disp_state_e           state_dbg
);

    disp_state_e   state_q, state_d;
    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [AW-1:0] digit_idx_q, digit_idx_d;
    logic [2:0]    b_lat_q, b_lat_d;
    logic          pending_q, pending_d;
    logic          commit_ack_q;
    logic          frame_wrap, apply;
    logic [31:0]   on_lim;

    always_ff @(posedge eclk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_cnt_q   <= '0;
            digit_idx_q  <= '0;
            b_lat_q      <= '0;
            pending_q    <= 1'b0;
            commit_ack_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            b_lat_q      <= b_lat_d;
            pending_q    <= pending_d;
            commit_ack_q <= apply;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        case (state_q)
            IDLE: begin
                state_d     = BLANK;
                slot_cnt_d  = '0;
                digit_idx_d = '0;
            end
            BLANK: begin
                slot_cnt_d = slot_cnt_q + 1'b1;
                if (slot_cnt_q == SW'(BLANK_CYCLES - 1)) state_d = DRIVE;
            end
            DRIVE: begin
                if (slot_cnt_q == SW'(PRESCALE - 1)) begin
                    slot_cnt_d  = '0;
                    digit_idx_d = digit_idx_q + 1'b1;
                    state_d     = BLANK;
                end else begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable overrides everything: park the scan at digit 0, slot 0.
        if (!en) begin
            state_d     = IDLE;
            slot_cnt_d  = '0;
            digit_idx_d = '0;
        end
    end

    // Brightness is sampled only in slot 0 so an on-time never changes mid-slot.
    assign b_lat_d = (slot_cnt_q == '0) ? brightness : b_lat_q;

    assign frame_wrap = (state_q == DRIVE) && (slot_cnt_q == SW'(PRESCALE - 1)) &&
                        (digit_idx_q == AW'(NUM_DIGITS - 1));
    assign apply      = pending_q && ((state_q == IDLE) || frame_wrap);
    assign pending_d  = commit || (pending_q && !apply);

    assign on_lim = 32'(BLANK_CYCLES) + on_cycles(32'(b_lat_q), PRESCALE, BLANK_CYCLES);

    always_comb begin
        an_sel = '0;
        if (state_q == DRIVE && 32'(slot_cnt_q) < on_lim) an_sel[digit_idx_q] = 1'b1;
    end

    assign frame_start = (state_q != IDLE) && (slot_cnt_q == '0) && (digit_idx_q == '0);
    assign digit_idx   = digit_idx_q;
    assign commit_ack  = commit_ack_q;
    assign state_dbg   = state_q;

    disp_digit_buf #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIGIT_W    (DIGIT_W)
    ) u_buf (
        .clk     (eclk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .apply   (apply),
        .rd_addr (digit_idx_q),
        .rd_data (digit_val)
    );

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random traffic, every cycle checked
// against a time-based reference model of the scan, buffers and commit rules.
module tb_disp_scan_ctrl;
    import disp_pkg::*;

    localparam int ND    = 8;
    localparam int P     = 20;
    localparam int B     = 4;
    localparam int DW    = 4;
    localparam int FRAME = P * ND;

    logic          eclk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic [2:0]    brightness = '0;
    logic [2:0]    digit_idx;
    logic [DW-1:0] digit_val;
    logic [ND-1:0] an_sel;
    logic          frame_start;
    logic          commit_ack;
    disp_state_e   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: scan position is just the cycle count since enable.
    bit          m_run;
    int          m_t;
    int          m_b;
    logic [DW-1:0] m_shadow [ND];
    logic [DW-1:0] m_active [ND];
    bit          m_pend;
    bit          m_ack;

    disp_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (P),
        .BLANK_CYCLES (B),
        .DIGIT_W      (DW)
    ) dut (
        .eclk        (eclk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit      (commit),
        .brightness  (brightness),
        .digit_idx   (digit_idx),
        .digit_val   (digit_val),
        .an_sel      (an_sel),
        .frame_start (frame_start),
        .commit_ack  (commit_ack),
        .state_dbg   (state_dbg)
    );

    always #5 eclk = ~eclk;

    function automatic int m_slot();
        return m_run ? (m_t % P) : 0;
    endfunction

    function automatic int m_digit();
        return m_run ? ((m_t / P) % ND) : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit apply;
        if (rst) begin
            m_run = 0; m_t = 0; m_b = 0; m_pend = 0; m_ack = 0;
            for (int i = 0; i < ND; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
        end else begin
            apply = m_pend && (!m_run || (m_t % FRAME == FRAME - 1));
            m_ack = apply;
            if (apply) for (int i = 0; i < ND; i++) m_active[i] = m_shadow[i];
            if (wr_en) m_shadow[wr_addr] = wr_data;
            m_pend = commit || (m_pend && !apply);
            if (!m_run || m_t % P == 0) m_b = int'(brightness);
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check_outputs();
        int on;
        logic [ND-1:0] exp_an;
        disp_state_e exp_st;
        on     = ((m_b + 1) * (P - B)) >> 3;
        exp_an = '0;
        if (m_run && m_slot() >= B && m_slot() < B + on) exp_an[m_digit()] = 1'b1;
        exp_st = !m_run ? IDLE : (m_slot() < B ? BLANK : DRIVE);
        check("an_sel", 32'(an_sel), 32'(exp_an));
        check("digit_idx", 32'(digit_idx), 32'(m_digit()));
        check("digit_val", 32'(digit_val), 32'(m_active[m_digit()]));
        check("frame_start", 32'(frame_start), 32'(m_run && (m_t % FRAME == 0)));
        check("commit_ack", 32'(commit_ack), 32'(m_ack));
        check("state", 32'(state_dbg), 32'(exp_st));
    endtask

    task automatic step();
        @(posedge eclk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Step at least once, until the model sits at (digit, slot); digit<0 matches any digit.
    task automatic step_until(input int d, input int s);
        int  n;
        bit  hit;
        n = 0;
        do begin
            step();
            n++;
            hit = m_run && (d < 0 || m_digit() == d) && m_slot() == s;
        end while (!hit && n < 400);
        check("wait_budget", 32'(hit), 32'd1);
    endtask

    initial begin
        int cnt1, cnt2, fs, last_fs, gap, cnt, found;

        // Reset and idle
        rst = 1'b1;
        step();
        step();
        check("rst_an_sel", 32'(an_sel), 32'd0);
        check("rst_digit_val", 32'(digit_val), 32'd0);
        rst = 1'b0;
        step();

        // Full brightness scan over two frames
        en = 1'b1;
        brightness = 3'd7;
        cnt1 = 0; cnt2 = 0; fs = 0; last_fs = -1; gap = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (an_sel == 8'h01) cnt1++;
            if (an_sel == 8'h02) cnt2++;
            if (frame_start) begin
                fs++;
                if (last_fs >= 0) gap = c - last_fs;
                last_fs = c;
            end
        end
        check("b7_on_digit0", 32'(cnt1), 32'd32);
        check("b7_on_digit1", 32'(cnt2), 32'd32);
        check("frame_start_count", 32'(fs), 32'd2);
        check("frame_start_gap", 32'(gap), 32'd160);

        // Brightness change mid-slot takes effect next slot
        brightness = 3'd0;
        step_until(-1, 0);
        cnt = 0;
        repeat (P) begin
            step();
            if (an_sel != '0) cnt++;
            if (m_slot() == 10) brightness = 3'd3;
        end
        check("b0_on_cycles", 32'(cnt), 32'd2);
        cnt = 0;
        repeat (P) begin
            step();
            if (an_sel != '0) cnt++;
        end
        check("b3_on_cycles", 32'(cnt), 32'd8);

        // Frame write + commit during digit 3, applied at the frame wrap
        step_until(3, 0);
        for (int i = 0; i < ND; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(9 - i);
            step();
        end
        wr_en = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            step();
            if (commit_ack) found = 1;
        end
        check("commit_ack_seen", 32'(found), 32'd1);
        check("ack_digit_idx", 32'(digit_idx), 32'd0);
        check("ack_digit_val", 32'(digit_val), 32'd9);
        step();
        check("ack_one_cycle", 32'(commit_ack), 32'd0);

        // Write in the apply cycle stays in shadow until the next commit
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd1;
        step();
        wr_en = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        step_until(7, 19);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd5;
        step();
        wr_en = 1'b0;
        check("apply_old_shadow", 32'(digit_val), 32'd1);
        check("apply_ack", 32'(commit_ack), 32'd1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        step_until(0, 0);
        check("second_commit_val", 32'(digit_val), 32'd5);

        // Disable during DRIVE of digit 5 with a commit pending
        step_until(5, 8);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hE; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        en = 1'b0;
        step();
        check("dis_an_sel", 32'(an_sel), 32'd0);
        check("dis_digit_idx", 32'(digit_idx), 32'd0);
        step();
        check("idle_apply_ack", 32'(commit_ack), 32'd1);
        check("idle_apply_val", 32'(digit_val), 32'hE);
        en = 1'b1;
        step();
        check("restart_frame_start", 32'(frame_start), 32'd1);
        check("restart_slot_state", 32'(state_dbg), 32'(BLANK));

        // Reset mid-DRIVE with a pending commit
        step_until(2, 10);
        commit = 1'b1;
        step();
        commit = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_an_sel", 32'(an_sel), 32'd0);
        check("midrst_ack", 32'(commit_ack), 32'd0);
        rst = 1'b0;
        step();
        step();
        check("postrst_no_ack", 32'(commit_ack), 32'd0);
        repeat (FRAME) step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 499) == 0);
            en      = ($urandom_range(0, 19) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, ND - 1));
            wr_data = 4'($urandom_range(0, 15));
            commit  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 15) == 0) brightness = 3'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
